// File: rtl/serial_src_pkg.sv
// Shared constants for the serial bit source: the FSM encoding and the default word width.
package serial_src_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/serial_bit_source.sv
// Parallel-to-serial source: one-word hold buffer feeding a shifter, one bit per clock on X.
// X idles at 0 so the downstream detector sees a clean zero background between words.
module serial_bit_source
  import serial_src_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             X,
  output logic             X_VALID,
  output logic             WORD_DONE,
  output logic             BUSY,
  output logic [0:0]       DBG_STATE
);

  // Handshake: a word moves on a rising edge where LOAD_VALID and LOAD_READY are both high;
  // upstream must hold DIN/LOAD_VALID stable until that edge, and LOAD_READY never depends on LOAD_VALID.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_transfer;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_head;

  assign w_accept   = LOAD_VALID & ~r_hold_full;
  assign w_last     = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
  assign w_transfer = r_hold_full & ((r_state == ST_IDLE) | w_last);

  // Zeros shift in behind the data, so the head reads 0 whenever nothing is being sent.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
      assign w_head       = r_shift[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
      assign w_head       = r_shift[0];
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= DIN;
      r_hold_full <= 1'b1;
    end else if (w_transfer) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_transfer) begin
      r_shift <= r_hold;
      r_cnt   <= '0;
    end else if (w_last) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_shift <= w_shift_next;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
    end else if (w_transfer) begin
      r_state <= ST_SHIFT;
    end else if (w_last) begin
      r_state <= ST_IDLE;
    end
  end

  assign LOAD_READY = ~r_hold_full;
  assign X          = w_head;
  assign X_VALID    = (r_state == ST_SHIFT);
  assign WORD_DONE  = w_last;
  assign BUSY       = X_VALID | r_hold_full;
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: an MSB-first and an LSB-first instance share one stimulus stream,
// and a word-level reference model predicts every output cycle by cycle.
module tb_serial_bit_source;

  localparam int W = 8;

  logic         clk;
  logic         n_rst;
  logic [W-1:0] din;
  logic         load_valid;

  logic         m_ready, m_x, m_xv, m_done, m_busy;
  logic [0:0]   m_state;
  logic         l_ready, l_x, l_xv, l_done, l_busy;
  logic [0:0]   l_state;

  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .nRST(n_rst), .DIN(din), .LOAD_VALID(load_valid),
    .LOAD_READY(m_ready), .X(m_x), .X_VALID(m_xv), .WORD_DONE(m_done),
    .BUSY(m_busy), .DBG_STATE(m_state)
  );

  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .nRST(n_rst), .DIN(din), .LOAD_VALID(load_valid),
    .LOAD_READY(l_ready), .X(l_x), .X_VALID(l_xv), .WORD_DONE(l_done),
    .BUSY(l_busy), .DBG_STATE(l_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           bit_idx;
  int           n_checks;
  int           n_pass;
  bit           mon_stop;

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
  endtask

  // Monitor: every negedge, apply the accept seen before the last edge, then predict and compare.
  initial begin
    logic         acc_pend;
    logic [W-1:0] acc_word;
    logic         fresh;
    logic         e_xv, e_hold, e_mbit, e_lbit, e_done;
    acc_pend = 1'b0;
    acc_word = '0;
    bit_idx  = 0;
    while (!mon_stop) begin
      @(negedge clk);
      fresh = 1'b0;
      if (acc_pend) begin
        fresh = (exp_q.size() == 0);
        exp_q.push_back(acc_word);
      end
      if (!n_rst) begin
        exp_q.delete();
        bit_idx = 0;
        fresh   = 1'b0;
      end
      e_mbit = 1'b0; e_lbit = 1'b0; e_done = 1'b0;
      if (fresh) begin
        e_xv = 1'b0; e_hold = 1'b1;
      end else if (exp_q.size() > 0) begin
        e_xv   = 1'b1;
        e_hold = (exp_q.size() > 1);
        e_mbit = exp_q[0][W-1-bit_idx];
        e_lbit = exp_q[0][bit_idx];
        e_done = (bit_idx == W-1);
        if (bit_idx == W-1) begin
          void'(exp_q.pop_front());
          bit_idx = 0;
        end else begin
          bit_idx++;
        end
      end else begin
        e_xv = 1'b0; e_hold = 1'b0;
      end
      chk("msb_x",         m_x,     e_mbit);
      chk("msb_x_valid",   m_xv,    e_xv);
      chk("msb_word_done", m_done,  e_done);
      chk("msb_load_ready", m_ready, ~e_hold);
      chk("msb_busy",      m_busy,  e_xv | e_hold);
      chk("lsb_x",         l_x,     e_lbit);
      chk("lsb_x_valid",   l_xv,    e_xv);
      chk("lsb_word_done", l_done,  e_done);
      acc_pend = n_rst & load_valid & m_ready;
      acc_word = din;
    end
  end

  // Driver tasks: inputs change 2 ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [W-1:0] w);
    logic rdy;
    int   waited;
    din        = w;
    load_valid = 1'b1;
    waited     = 0;
    forever begin
      rdy = m_ready;
      step();
      if (rdy) break;
      waited++;
      if (waited > 100) begin
        $display("FAIL send_timeout: word %h not accepted after %0d cycles", w, waited);
        $fatal(1, "handshake stalled");
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    mon_stop   = 1'b0;
    n_rst      = 1'b0;
    din        = '0;
    load_valid = 1'b0;
    #27 n_rst = 1'b1;
    idle(3);

    // Single word
    send(8'b1011_0010);
    idle(12);

    // Back-to-back: second word offered as soon as the first is taken
    send(8'hA5);
    send(8'h3C);
    idle(20);

    // Backpressure: three words with LOAD_VALID held high throughout
    send(8'h96);
    send(8'h5A);
    send(8'hC3);
    idle(28);

    // Reset mid-word with a word held
    send(8'hFF);
    send(8'h0F);
    step();
    step();
    n_rst = 1'b0;
    idle(2);
    n_rst = 1'b1;
    idle(12);

    // LSB-first reference word
    send(8'h01);
    idle(12);

    // Random words with random gaps
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom_range(0, 255)));
      idle($urandom_range(0, 10));
    end
    idle(2 * W + 5);

    mon_stop = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parallel-to-serial stage that feeds the `SequenceDetector` stage: it accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `X`, first bit first. A one-word holding buffer lets a following word stream out with no idle cycle between words. When no data is pending, `X` idles at 0, so the detector sees a clean zero background.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends `DIN[WIDTH-1]` first; 0 sends `DIN[0]` first.

Ports, clock and reset first:
- `CLK` in 1: single clock; all state changes on the rising edge.
- `nRST` in 1: reset, asynchronous and active-low.
- `DIN` in WIDTH: word to serialize; sampled only on an accepted load.
- `LOAD_VALID` in 1: upstream offers `DIN`.
- `LOAD_READY` out 1: block can take a word. Registered; equals `!hold_full`.
- `X` out 1: serial bit to the detector. Registered; 0 when not shifting.
- `X_VALID` out 1: high while `X` carries a data bit.
- `WORD_DONE` out 1: high during the cycle the last bit of a word is on `X`.
- `BUSY` out 1: `X_VALID | hold_full`.

## Operation
- State `IDLE`:
  - `X=0`, `X_VALID=0`.
  - If `hold_full` is set, transfer the hold register into the shifter, set `cnt=0` and go to `SHIFT`.
- State `SHIFT`:
  - `X` is the current head bit of the shifter; each edge shifts it by one and increments `cnt`.
  - When `cnt==WIDTH-1` (last bit on `X`), `WORD_DONE=1`.
  - On that edge, if `hold_full`, the next word transfers and the state stays `SHIFT` (gapless).
  - Otherwise the state goes to `IDLE`.
- Load handshake:
  - A word is accepted on an edge where `LOAD_VALID & LOAD_READY`; it is written to hold and `hold_full` is set.
  - A transfer out of hold clears `hold_full`.
  - An accept and a transfer never coincide, because `LOAD_READY=0` whenever hold is full.
- `DIN` and `LOAD_VALID` are ignored while `LOAD_READY=0`. A word offered then is not lost; upstream keeps it.
- `cnt` width: `$clog2(WIDTH)`. No wrap-around beyond WIDTH-1; it resets to 0 on every transfer.
- Reset values: state `IDLE`, shifter 0, hold 0, `hold_full=0`, `cnt=0`. Outputs: `X=0`, `X_VALID=0`, `WORD_DONE=0`, `BUSY=0`, `LOAD_READY=1`.
- Reset mid-word: an asserted `nRST` clears everything immediately, asynchronously. The partial word and any held word are discarded, and the output does not resume the partial word after release.

## Timing
- Accept at edge k with the block idle:
  - Hold fills at k; the shifter loads at k+1.
  - Bit i (send order, i=0..WIDTH-1) is on `X` from edge k+1+i to edge k+2+i.
  - Load-to-first-bit latency is 1 cycle.
- `WORD_DONE` coincides with bit WIDTH-1, in cycle k+WIDTH.
- `LOAD_READY` after an accept:
  - It drops after edge k and rises again after edge k+1, once hold empties.
  - A second word accepted at any edge from k+2 to k+WIDTH starts at edge k+1+WIDTH with no gap.
- Sustained throughput is 1 bit per clock when upstream refills hold within WIDTH-1 cycles of each transfer.
- Release of `nRST` between edges: the first accept is possible on the next rising edge.

## Structure
- Shared package `serial_src_pkg`:
  - state encoding `ST_IDLE=1'b0`, `ST_SHIFT=1'b1`;
  - default `WIDTH` constant.
- Single flat module, with three registered sections:
  - hold register;
  - shifter and counter;
  - state register.
- No sub-module: the hold buffer is one entry and does not justify a separate FIFO.
- Shift direction is selected by `MSB_FIRST` through a generate branch. No muxing in the `X` path beyond the shifter head.

## Test plan
All scenarios use WIDTH=8, MSB_FIRST=1 and a 10 ns clock unless stated.
- Reset: hold `nRST=0` for 20 ns -> `X=0`, `X_VALID=0`, `LOAD_READY=1`, `BUSY=0` during reset and after release.
- Single word: load 8'b1011_0010 at edge k -> `X` shows 1,0,1,1,0,0,1,0 on edges k+1..k+8; `WORD_DONE` high only in cycle k+8; `X` returns to 0 after k+9.
- Back-to-back: load 8'hA5 then 8'h3C as soon as `LOAD_READY` rises -> 16 contiguous valid bits 10100101_00111100 with no gap; `LOAD_READY` low exactly while hold is full.
- Backpressure: keep `LOAD_VALID=1` with a third word while hold is full -> the word is not accepted until `LOAD_READY=1`; no word is dropped or duplicated (compare against a scoreboard queue).
- Reset mid-word: assert `nRST` after bit 3 of 8'hFF, with 8'h0F held -> `X` goes to 0 immediately; after release nothing is emitted until a new load.
- LSB-first build (MSB_FIRST=0): load 8'h01 -> `X` sequence 1,0,0,0,0,0,0,0; `WORD_DONE` aligned with the eighth bit.
